// File: rtl/keypad_scanner.sv
// Column-sequenced 3x4 keypad scanner with whole-frame debounce and a one-cycle key strobe.
// Optional auto-repeat of the held key is built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scanner #(
  parameter int SCAN_DIV            = 3300,
  parameter int DEBOUNCE_SCANS      = 4,
  parameter int REPEAT_DELAY_FRAMES = 500,
  parameter int REPEAT_RATE_FRAMES  = 100
) (
  input  logic       CLK_3P3_MHZ,
  input  logic       RESET,
  input  logic [3:0] KEYPAD_ROW,
  output logic [2:0] KEYPAD_COL,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       KEY_DOWN
);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 ||
      REPEAT_DELAY_FRAMES < 1 || REPEAT_RATE_FRAMES < 1) begin : g_param_check
    $error("keypad_scanner: illegal parameter value");
  end

  localparam int DIV_W = $clog2(SCAN_DIV);

  // IDLE only exists between reset release and the first COL0
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_COL0 = 3'd1;
  localparam logic [2:0] S_COL1 = 3'd2;
  localparam logic [2:0] S_COL2 = 3'd3;
  localparam logic [2:0] S_EVAL = 3'd4;

  // Frame result is {kind, key index}
  localparam logic [1:0] R_NONE   = 2'd0;
  localparam logic [1:0] R_SINGLE = 2'd1;
  localparam logic [1:0] R_MULTI  = 2'd2;
  localparam logic [5:0] RES_NONE = {R_NONE, 4'd0};

  logic [2:0]       state;
  logic [DIV_W-1:0] dwell;
  logic [3:0]       row_meta, row_sync;
  logic [11:0]      frame;
  logic [1:0]       col_idx;
  logic             dwell_done, is_eval;

  logic [3:0] ones, idx;
  logic [5:0] result, cand, accepted;
  logic [3:0] cnt, cnt_next;
  logic       accept, rpt_hit;

  always_ff @(posedge CLK_3P3_MHZ or posedge RESET) begin
    if (RESET) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= KEYPAD_ROW;
      row_sync <= row_meta;
    end
  end

  assign dwell_done = (dwell == DIV_W'(SCAN_DIV - 1));
  assign is_eval    = (state == S_EVAL);

  always_comb begin
    col_idx    = 2'd0;
    KEYPAD_COL = 3'b111;
    case (state)
      S_COL0: begin col_idx = 2'd0; KEYPAD_COL = 3'b110; end
      S_COL1: begin col_idx = 2'd1; KEYPAD_COL = 3'b101; end
      S_COL2: begin col_idx = 2'd2; KEYPAD_COL = 3'b011; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_3P3_MHZ or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      dwell <= '0;
      frame <= '0;
    end else begin
      case (state)
        S_COL0, S_COL1, S_COL2: begin
          if (dwell_done) begin
            dwell <= '0;
            for (int r = 0; r < 4; r++) frame[r*3 + int'(col_idx)] <= ~row_sync[r];
            state <= (state == S_COL2) ? S_EVAL : state + 3'd1;
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        default: begin
          dwell <= '0;
          state <= S_COL0;
        end
      endcase
    end
  end

  always_comb begin
    ones = '0;
    idx  = '0;
    for (int k = 0; k < 12; k++) begin
      if (frame[k]) begin
        ones = ones + 4'd1;
        idx  = 4'(k);
      end
    end
    if (ones == 4'd0)      result = RES_NONE;
    else if (ones == 4'd1) result = {R_SINGLE, idx};
    else                   result = {R_MULTI, 4'd0};
  end

  // A stable MULTI never becomes the accepted result, so it never strobes
  always_comb begin
    if (result == cand) cnt_next = (cnt == 4'(DEBOUNCE_SCANS)) ? cnt : cnt + 4'd1;
    else                cnt_next = 4'd1;
    accept = (cnt_next == 4'(DEBOUNCE_SCANS)) && (result != accepted) &&
             (result[5:4] != R_MULTI);
  end

  always_ff @(posedge CLK_3P3_MHZ or posedge RESET) begin
    if (RESET) begin
      cand      <= RES_NONE;
      accepted  <= RES_NONE;
      cnt       <= '0;
      KEY_CODE  <= '0;
      KEY_DOWN  <= 1'b0;
      KEY_VALID <= 1'b0;
    end else begin
      KEY_VALID <= is_eval && ((accept && result[5:4] == R_SINGLE) || rpt_hit);
      if (is_eval) begin
        cand <= result;
        cnt  <= cnt_next;
        if (accept) begin
          accepted <= result;
          if (result[5:4] == R_SINGLE) begin
            KEY_CODE <= result[3:0];
            KEY_DOWN <= 1'b1;
          end else begin
            KEY_DOWN <= 1'b0;
          end
        end
      end
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                           REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt, rpt_limit;
  logic             rpt_phase, rpt_held;

  // Frames only count while the key is still seen, so a release stops repeats at once
  assign rpt_held  = (accepted[5:4] == R_SINGLE) && (result == accepted);
  assign rpt_limit = rpt_phase ? RPT_W'(REPEAT_RATE_FRAMES) : RPT_W'(REPEAT_DELAY_FRAMES);
  assign rpt_hit   = is_eval && !accept && rpt_held && (rpt_cnt == rpt_limit - 1'b1);

  always_ff @(posedge CLK_3P3_MHZ or posedge RESET) begin
    if (RESET) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (is_eval) begin
      if (accept) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
      end else if (rpt_hit) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b1;
      end else if (rpt_held) begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end
`else
  assign rpt_hit = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a matrix model drives rows from the column drive,
// and a scoreboard queue holds the key code expected for each KEY_VALID strobe.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [2:0]  col;
  logic [3:0]  code;
  logic        valid, down;
  logic [11:0] pressed;

  int cyc = 0, strobes = 0, strobe_cyc = 0;
  int n_assert = 0, fails = 0;
  int exp_q[$];
  int c0;

  keypad_scanner #(
    .SCAN_DIV(4), .DEBOUNCE_SCANS(3), .REPEAT_DELAY_FRAMES(5), .REPEAT_RATE_FRAMES(2)
  ) dut (
    .CLK_3P3_MHZ(clk), .RESET(rst), .KEYPAD_ROW(row), .KEYPAD_COL(col),
    .KEY_CODE(code), .KEY_VALID(valid), .KEY_DOWN(down)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A pressed key pulls its row low only while its column is driven low
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst && valid) begin
      strobes++;
      strobe_cyc = cyc;
      n_assert++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_strobe: observed code %0d, expected no strobe", code);
      end
      if (exp_q.size() != 0) begin
        int e;
        e = exp_q.pop_front();
        n_assert++;
        assert (int'(code) === e) else begin
          fails++;
          $error("FAIL strobe_code: observed %0d expected %0d", code, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Returns just after the negedge of an EVAL cycle; the next posedge starts COL0
  task automatic frame_start();
    int i;
    for (i = 0; i < 40; i++) begin
      step(1);
      if (col == 3'b111) break;
    end
    chk("frame_start_timeout", int'(i < 40), 1);
  endtask

  task automatic wait_strobes(input string tag, input int target, input int bound);
    for (int i = 0; i < bound && strobes < target; i++) step(1);
    chk(tag, strobes, target);
  endtask

  task automatic wait_up(input string tag);
    int i;
    for (i = 0; i < 80 && down; i++) step(1);
    chk(tag, int'(down), 0);
  endtask

  initial begin
    rst = 1'b1;
    pressed = '0;
    step(3);
    chk("reset_col", int'(col), 7);
    chk("reset_code", int'(code), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_down", int'(down), 0);

    // Idle: two full frames of column sequencing
    rst = 1'b0;
    for (int i = 0; i < 26; i++) begin
      int k;
      k = i % 13;
      step(1);
      chk("col_seq", int'(col), (k < 4) ? 6 : (k < 8) ? 5 : (k < 12) ? 3 : 7);
    end
    chk("idle_strobes", strobes, 0);
    chk("idle_down", int'(down), 0);

`ifdef KEYPAD_AUTOREPEAT_EN
    frame_start();
    pressed = 12'(1) << 9;
    exp_q.push_back(9);
    c0 = cyc;
    wait_strobes("rpt_accept", 1, 60);
    chk("rpt_accept_lat", strobe_cyc - c0, 40);
    exp_q.push_back(9);
    wait_strobes("rpt_first", 2, 80);
    chk("rpt_first_lat", strobe_cyc - c0, 40 + 65);
    exp_q.push_back(9);
    wait_strobes("rpt_second", 3, 40);
    chk("rpt_second_lat", strobe_cyc - c0, 40 + 65 + 26);
    exp_q.push_back(9);
    wait_strobes("rpt_third", 4, 40);
    chk("rpt_third_lat", strobe_cyc - c0, 40 + 65 + 52);
    pressed = '0;
    wait_up("rpt_release_down");
    step(39);
    chk("rpt_release_strobes", strobes, 4);
`else
    // Stable key 7 (row 2, col 1)
    frame_start();
    pressed = 12'(1) << 7;
    exp_q.push_back(7);
    c0 = cyc;
    wait_strobes("k7_strobe", 1, 60);
    chk("k7_latency", strobe_cyc - c0, 40);
    chk("k7_down", int'(down), 1);
    step(52);
    chk("k7_single_strobe", strobes, 1);
    frame_start();
    pressed = '0;
    c0 = cyc;
    step(39);
    chk("k7_down_held", int'(down), 1);
    step(1);
    chk("k7_down_release", int'(down), 0);

    // Key 4 bouncing, then stable from a frame boundary
    frame_start();
    for (int i = 0; i < 10; i++) begin
      pressed[4] = ~pressed[4];
      step(5);
    end
    pressed = '0;
    chk("bounce_no_strobe", strobes, 1);
    frame_start();
    frame_start();
    pressed = 12'(1) << 4;
    exp_q.push_back(4);
    c0 = cyc;
    wait_strobes("k4_strobe", 2, 60);
    chk("k4_latency", strobe_cyc - c0, 40);
    frame_start();
    pressed = '0;
    wait_up("k4_release");

    // Key 5 accepted, then reset in the middle of COL1
    frame_start();
    pressed = 12'(1) << 5;
    exp_q.push_back(5);
    wait_strobes("k5_strobe", 3, 60);
    for (int i = 0; i < 20 && col != 3'b101; i++) step(1);
    chk("k5_reach_col1", int'(col), 5);
    step(1);
    rst = 1'b1;
    #1;
    chk("midreset_col", int'(col), 7);
    chk("midreset_code", int'(code), 0);
    chk("midreset_down", int'(down), 0);
    chk("midreset_valid", int'(valid), 0);
    step(2);
    rst = 1'b0;
    exp_q.push_back(5);
    c0 = cyc;
    wait_strobes("k5_after_reset", 4, 60);
    chk("k5_after_reset_lat", strobe_cyc - c0, 40);
    pressed = '0;
    wait_up("k5_release");

    // Key 0 held, key 11 added then removed
    frame_start();
    pressed = 12'(1);
    exp_q.push_back(0);
    wait_strobes("k0_strobe", 5, 60);
    frame_start();
    pressed[11] = 1'b1;
    step(65);
    chk("multi_code", int'(code), 0);
    chk("multi_down", int'(down), 1);
    pressed[11] = 1'b0;
    step(65);
    chk("multi_ret_code", int'(code), 0);
    chk("multi_ret_down", int'(down), 1);
    chk("multi_no_strobe", strobes, 5);
    pressed = '0;
    wait_up("k0_release");
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, fails);
    $finish;
  end

endmodule
